// File: rtl/eth_rx_byte_packer.sv
// Packs MAC receive bytes little-endian into a 512 x 32-bit frame buffer for host readout.
// Define ETH_RX_FCS_STRIP_EN to report lengths without the 4-byte FCS and drop frames under 5 bytes.
module eth_rx_byte_packer #(
   parameter int unsigned DROP_CNT_W = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rx_valid_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_sof_i,
   input  logic                  rx_eof_i,
   input  logic                  rx_err_i,
   input  logic                  rd_en_i,
   input  logic [8:0]            rd_addr_i,
   output logic [31:0]           rd_data_o,
   input  logic                  release_i,
   output logic                  frame_ready_o,
   output logic [10:0]           frame_len_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_DROP} state_t;

   localparam int unsigned SUM_W = DROP_CNT_W + 2;
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

   state_t                state_q, state_d;
   logic [11:0]           cnt_q, cnt_d;
   logic [31:0]           stage_q, stage_d;
   logic [10:0]           len_q, len_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic [SUM_W-1:0]      drop_sum;
   logic [1:0]            drop_inc;
   logic                  start_frame, accept;
   logic [11:0]           acc_idx;
   logic [31:0]           acc_base, merged;
   logic                  wr_en;
   logic [8:0]            wr_addr;
   logic [31:0]           wr_data;
   logic [31:0]           mem_q [512];
   logic [31:0]           rd_data_q;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      len_d       = len_q;
      drop_inc    = 2'd0;
      start_frame = 1'b0;
      accept      = 1'b0;
      acc_idx     = cnt_q;
      acc_base    = stage_q;
      merged      = stage_q;
      wr_en       = 1'b0;
      wr_addr     = cnt_q[10:2];
      wr_data     = stage_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid_i && rx_sof_i) start_frame = 1'b1;
         end
         S_DROP: begin
            if (rx_valid_i && rx_sof_i)      start_frame = 1'b1;
            else if (rx_valid_i && rx_eof_i) state_d = S_IDLE;
         end
         S_RECV: begin
            if (rx_valid_i) begin
               if (rx_sof_i) begin
                  drop_inc    = 2'd1;
                  start_frame = 1'b1;
               end else if (rx_err_i || cnt_q[11]) begin
                  // cnt_q[11] set means this is byte 2049: no room left in the buffer
                  drop_inc = 2'd1;
                  state_d  = rx_eof_i ? S_IDLE : S_DROP;
               end else begin
                  accept = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (rx_valid_i && rx_sof_i) begin
               drop_inc = 2'd1;
               state_d  = S_DROP;
            end else if (release_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start_frame) begin
         acc_idx  = 12'd0;
         acc_base = 32'd0;
         cnt_d    = 12'd0;
         stage_d  = 32'd0;
         if (rx_err_i) begin
            drop_inc = drop_inc + 2'd1;
            state_d  = rx_eof_i ? S_IDLE : S_DROP;
         end else begin
            accept  = 1'b1;
            state_d = S_RECV;
         end
      end

      if (accept) begin
         merged = acc_base;
         merged[{acc_idx[1:0], 3'b000} +: 8] = rx_data_i;
         cnt_d = acc_idx + 12'd1;
         if (acc_idx[1:0] == 2'd3 || rx_eof_i) begin
            wr_en   = 1'b1;
            wr_addr = acc_idx[10:2];
            wr_data = merged;
            stage_d = 32'd0;
         end else begin
            stage_d = merged;
         end
         if (rx_eof_i) begin
`ifdef ETH_RX_FCS_STRIP_EN
            if (cnt_d < 12'd5) begin
               drop_inc = drop_inc + 2'd1;
               state_d  = S_IDLE;
            end else begin
               len_d   = 11'(cnt_d - 12'd4);
               state_d = S_DONE;
            end
`else
            len_d   = cnt_d[10:0];
            state_d = S_DONE;
`endif
         end
      end

      drop_sum = {2'b00, drop_q} + SUM_W'(drop_inc);
      drop_d   = (drop_sum[SUM_W-1:DROP_CNT_W] != 2'b00) ? DROP_MAX : drop_sum[DROP_CNT_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 12'd0;
         stage_q <= 32'd0;
         len_q   <= 11'd0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         len_q   <= len_d;
         drop_q  <= drop_d;
      end
   end

   // NOTE: the buffer array is deliberately not reset so it maps onto plain block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en && !rst_i) mem_q[wr_addr] <= wr_data;
   end

   // A read of the word being written returns the old contents (read-before-write).
   always_ff @(posedge clk_i) begin
      if (rst_i)        rd_data_q <= 32'd0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign frame_ready_o = (state_q == S_DONE);
   assign frame_len_o   = len_q;
   assign drop_cnt_o    = drop_q;
   assign rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_eth_rx_byte_packer.sv
// Directed bench for eth_rx_byte_packer (default build, DROP_CNT_W = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge after the active edge.
module tb_eth_rx_byte_packer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_data_i = 8'd0;
   logic        rx_sof_i = 1'b0;
   logic        rx_eof_i = 1'b0;
   logic        rx_err_i = 1'b0;
   logic        rd_en_i = 1'b0;
   logic [8:0]  rd_addr_i = 9'd0;
   logic [31:0] rd_data_o;
   logic        release_i = 1'b0;
   logic        frame_ready_o;
   logic [10:0] frame_len_o;
   logic [7:0]  drop_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   eth_rx_byte_packer #(.DROP_CNT_W(8)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rx_valid_i    (rx_valid_i),
      .rx_data_i     (rx_data_i),
      .rx_sof_i      (rx_sof_i),
      .rx_eof_i      (rx_eof_i),
      .rx_err_i      (rx_err_i),
      .rd_en_i       (rd_en_i),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .release_i     (release_i),
      .frame_ready_o (frame_ready_o),
      .frame_len_o   (frame_len_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic sof, input logic eof, input logic err);
      rx_valid_i = 1'b1;
      rx_data_i  = d;
      rx_sof_i   = sof;
      rx_eof_i   = eof;
      rx_err_i   = err;
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      rx_sof_i   = 1'b0;
      rx_eof_i   = 1'b0;
      rx_err_i   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) send(first + 8'(i), i == 0, i == n - 1, 1'b0);
   endtask

   task automatic read_word(input logic [8:0] a, output logic [31:0] d);
      rd_en_i   = 1'b1;
      rd_addr_i = a;
      @(negedge clk_i);
      rd_en_i = 1'b0;
      d = rd_data_o;
   endtask

   task automatic release_pulse();
      release_i = 1'b1;
      @(negedge clk_i);
      release_i = 1'b0;
   endtask

   initial begin
      logic [31:0] w;

      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check("reset_ready", frame_ready_o, 0);
      check("reset_len", frame_len_o, 0);
      check("reset_drop", drop_cnt_o, 0);
      check("reset_rdata", rd_data_o, 0);

      // basic 6-byte frame, partial last word
      send_frame(8'h01, 6);
      check("f6_ready", frame_ready_o, 1);
      check("f6_len", frame_len_o, 6);
      read_word(9'd0, w);
      check("f6_word0", w, 32'h04030201);
      read_word(9'd1, w);
      check("f6_word1", w, 32'h00000605);
      rd_addr_i = 9'd0;
      @(negedge clk_i);
      check("rd_hold", rd_data_o, 32'h00000605);
      release_pulse();
      check("release_clears_ready", frame_ready_o, 0);

      // stray byte in IDLE is ignored
      send(8'hEE, 1'b0, 1'b0, 1'b0);
      check("idle_stray_ready", frame_ready_o, 0);
      check("idle_stray_drop", drop_cnt_o, 0);

      // error on byte 3 of a 10-byte frame, then a good 5-byte frame
      for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), i == 0, i == 9, i == 2);
      check("err_ready", frame_ready_o, 0);
      check("err_drop", drop_cnt_o, 1);
      send_frame(8'hA0, 5);
      check("after_err_ready", frame_ready_o, 1);
      check("after_err_len", frame_len_o, 5);
      read_word(9'd0, w);
      check("after_err_word0", w, 32'hA3A2A1A0);
      read_word(9'd1, w);
      check("after_err_word1", w, 32'h000000A4);
      release_pulse();

      // sof inside a running frame restarts it
      send(8'h11, 1'b1, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0, 1'b0);
      send(8'h33, 1'b1, 1'b0, 1'b0);
      send(8'h44, 1'b0, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b1, 1'b0);
      check("restart_drop", drop_cnt_o, 2);
      check("restart_len", frame_len_o, 3);
      read_word(9'd0, w);
      check("restart_word0", w, 32'h00554433);
      release_pulse();

      // 2049 bytes without eof overflow the buffer
      for (int i = 0; i < 2049; i++) send(i[7:0], i == 0, 1'b0, 1'b0);
      check("ovf_drop", drop_cnt_o, 3);
      check("ovf_ready", frame_ready_o, 0);
      for (int i = 0; i < 3; i++) send(8'h5C, 1'b0, 1'b0, 1'b0);
      send(8'h5D, 1'b0, 1'b1, 1'b0);
      check("ovf_eof_ready", frame_ready_o, 0);
      check("ovf_eof_drop", drop_cnt_o, 3);
      read_word(9'd511, w);
      check("ovf_word511", w, 32'hFFFEFDFC);
      read_word(9'd0, w);
      check("ovf_word0", w, 32'h03020100);

      // single-byte frame, then held while another frame arrives
      send(8'h5A, 1'b1, 1'b1, 1'b0);
      check("one_byte_ready", frame_ready_o, 1);
      check("one_byte_len", frame_len_o, 1);
      send(8'h77, 1'b0, 1'b0, 1'b0);
      check("done_stray_ready", frame_ready_o, 1);
      send(8'h99, 1'b1, 1'b0, 1'b0);
      check("done_sof_ready", frame_ready_o, 0);
      check("done_sof_drop", drop_cnt_o, 4);
      send(8'h98, 1'b0, 1'b0, 1'b0);
      send(8'h97, 1'b0, 1'b1, 1'b0);
      release_pulse();
      check("held_release_ready", frame_ready_o, 0);
      read_word(9'd0, w);
      check("held_word0", w, 32'h0000005A);
      check("held_drop", drop_cnt_o, 4);

      // release and sof in the same DONE cycle: the drop wins
      send(8'h66, 1'b1, 1'b1, 1'b0);
      check("pre_race_ready", frame_ready_o, 1);
      release_i = 1'b1;
      send(8'h10, 1'b1, 1'b0, 1'b0);
      release_i = 1'b0;
      check("race_ready", frame_ready_o, 0);
      check("race_drop", drop_cnt_o, 5);
      send(8'h20, 1'b0, 1'b1, 1'b0);
      read_word(9'd0, w);
      check("race_word0", w, 32'h00000066);

      // reset on byte 5 of a frame
      for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), i == 0, 1'b0, 1'b0);
      rst_i = 1'b1;
      send(8'hB4, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
      check("midrst_ready", frame_ready_o, 0);
      check("midrst_len", frame_len_o, 0);
      check("midrst_drop", drop_cnt_o, 0);
      check("midrst_rdata", rd_data_o, 0);
      send_frame(8'hC1, 6);
      check("post_rst_len", frame_len_o, 6);
      read_word(9'd0, w);
      check("post_rst_word0", w, 32'hC4C3C2C1);
      read_word(9'd1, w);
      check("post_rst_word1", w, 32'h0000C6C5);
      release_pulse();

      // 300 errored frames saturate the 8-bit drop counter
      for (int i = 0; i < 300; i++) begin
         send(i[7:0], 1'b1, 1'b1, 1'b1);
         if (i == 9) check("sat_drop_10", drop_cnt_o, 10);
      end
      check("sat_drop_255", drop_cnt_o, 255);
      check("sat_ready", frame_ready_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
